// File: rtl/pack_rq0_if.sv
// Handshake bundle for pack_rq0: coefficient-pair input, byte output and run control.
interface pack_rq0_if #(
  parameter int COEF_BITS = 13
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [COEF_BITS-1:0] even;
  logic [COEF_BITS-1:0] odd;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, in_valid, even, odd, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, in_valid, even, odd, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/pack_rq0.sv
// Packs N-1 coefficients of COEF_BITS bits into an LSB-first byte stream,
// one even/odd pair in, bytes out, through a small bit accumulator.
module pack_rq0 #(
  parameter int N         = 701,
  parameter int COEF_BITS = 13
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  pack_rq0_if.slave  bus_if
);
  localparam int PAIRS  = (N - 1) / 2;
  localparam int BYTES  = ((N - 1) * COEF_BITS + 7) / 8;
  localparam int PAIR_W = 2 * COEF_BITS;
  localparam int ACC_W  = 40;
  localparam int FILL_W = 6;
  localparam int PCW    = $clog2(PAIRS + 1);
  localparam int BCW    = $clog2(BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PCW-1:0]     pair_cnt_q, pair_cnt_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;

  logic in_ready, out_valid, busy, done;
  logic in_hs, out_hs;
  logic [ACC_W-1:0] pair_ext;

  assign pair_ext = {{(ACC_W-PAIR_W){1'b0}}, bus_if.odd, bus_if.even};
  assign in_hs    = in_ready && bus_if.in_valid;
  assign out_hs   = out_valid && bus_if.out_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    pair_cnt_d = pair_cnt_q;
    byte_cnt_d = byte_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          state_d    = S_RUN;
          acc_d      = '0;
          fill_d     = '0;
          pair_cnt_d = '0;
          byte_cnt_d = '0;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        // Fill ranges for accepting (<8) and emitting (>=8) are disjoint.
        in_ready  = (fill_q < FILL_W'(8)) && (pair_cnt_q < PCW'(PAIRS));
        out_valid = (fill_q >= FILL_W'(8));
        if (in_hs) begin
          acc_d      = acc_q | (pair_ext << fill_q);
          fill_d     = fill_q + FILL_W'(PAIR_W);
          pair_cnt_d = pair_cnt_q + 1'b1;
        end else if (out_hs) begin
          acc_d      = acc_q >> 8;
          fill_d     = fill_q - FILL_W'(8);
          byte_cnt_d = byte_cnt_q + 1'b1;
        end else if (pair_cnt_q == PCW'(PAIRS) && fill_q < FILL_W'(8)) begin
          state_d = (fill_q != '0) ? S_FLUSH : S_DONE;
        end
      end
      S_FLUSH: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_hs) begin
          acc_d      = acc_q >> 8;
          fill_d     = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      fill_q     <= '0;
      pair_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      pair_cnt_q <= pair_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // A completed run must have emitted exactly BYTES bytes.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q == S_DONE) assert (byte_cnt_q == BCW'(BYTES));
  end

  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = out_valid;
  assign bus_if.out_data  = acc_q[7:0];
  assign bus_if.busy      = busy;
  assign bus_if.done      = done;
endmodule

// File: tb/tb_pack_rq0.sv
// Randomised bench for pack_rq0: expected bytes come from a bit-level stream model.
module tb_pack_rq0;
  localparam int N     = 701;
  localparam int NC    = N - 1;
  localparam int PAIRS = NC / 2;
  localparam int BYTES = (NC * 13 + 7) / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pack_rq0_if #(.COEF_BITS(13)) bus ();
  pack_rq0 #(.N(N), .COEF_BITS(13)) dut (.clk_i(clk), .rst_ni(rst_n), .bus_if(bus));

  logic [12:0] coef  [NC];
  logic [7:0]  exp_b [BYTES];
  logic [7:0]  got_b [BYTES];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic set_coef(input int mode);
    for (int i = 0; i < NC; i++) begin
      case (mode)
        0: coef[i] = '0;
        1: coef[i] = (i % 2 == 0) ? 13'h1FFF : 13'h0000;
        2: coef[i] = (i >= 698) ? 13'h1FFF : 13'h0000;
        default: coef[i] = 13'($urandom);
      endcase
    end
  endtask

  // Byte j bit b is stream bit 8j+b, i.e. bit (8j+b)%13 of coefficient (8j+b)/13.
  task automatic build_exp();
    for (int j = 0; j < BYTES; j++) begin
      exp_b[j] = '0;
      for (int b = 0; b < 8; b++) begin
        int s;
        s = 8 * j + b;
        if (s / 13 < NC) exp_b[j][b] = coef[s / 13][s % 13];
      end
    end
  endtask

  task automatic unpack_check();
    int errs;
    errs = 0;
    for (int i = 0; i < NC; i++) begin
      logic [12:0] c;
      for (int b = 0; b < 13; b++) begin
        int s;
        s = 13 * i + b;
        c[b] = got_b[s / 8][s % 8];
      end
      if (c != coef[i]) errs++;
    end
    chk("unpack_coef_errors", errs, 0);
  endtask

  // Drives one packing run. stall_mode 1: 5-cycle stall at byte 200, then 50% ready.
  task automatic run(input int gap_pct, input int stall_mode, input int start_at, input int rst_at);
    int idx, sent, cyc, last_hs, dones, stall_left;
    bit stalled, stall_done, fin, do_rst;
    logic [7:0] held;
    idx = 0; sent = 0; cyc = 0; last_hs = -10; dones = 0; stall_left = 0;
    stalled = 0; stall_done = 0; fin = 0; do_rst = 0; held = '0;
    for (int j = 0; j < BYTES; j++) got_b[j] = '0;
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", int'(bus.busy), 1);
    @(posedge clk); #1;
    while (!fin && cyc < 30000) begin
      bus.in_valid = (sent < PAIRS) && ($urandom_range(99) >= gap_pct);
      if (sent < PAIRS) begin
        bus.even = coef[2 * sent];
        bus.odd  = coef[2 * sent + 1];
      end else begin
        bus.even = 13'($urandom);
        bus.odd  = 13'($urandom);
      end
      bus.start = (start_at >= 0) && (sent == start_at);
      if (stall_mode == 1) begin
        if (!stall_done && idx >= 200) begin stall_left = 5; stall_done = 1; end
        if (stall_left > 0) begin bus.out_ready = 1'b0; stall_left--; end
        else if (stall_done) bus.out_ready = 1'($urandom_range(1));
        else bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (do_rst) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (stalled) begin
        chk("stall_hold_valid", int'(bus.out_valid), 1);
        chk("stall_hold_data", int'(bus.out_data), int'(held));
      end
      if (bus.out_valid && bus.in_ready) chk("in_out_exclusive", 1, 0);
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        if (idx < BYTES) begin
          chk("byte", int'(bus.out_data), int'(exp_b[idx]));
          got_b[idx] = bus.out_data;
        end else begin
          chk("extra_byte", idx, BYTES - 1);
        end
        idx++;
        last_hs = cyc;
        if (rst_at >= 0 && idx == rst_at) do_rst = 1;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.done) begin
        dones++;
        chk("done_count", dones, 1);
        chk("done_bytes", idx, BYTES);
        chk("done_latency", cyc - last_hs, 1);
        chk("done_pairs", sent, PAIRS);
        chk("busy_at_done", int'(bus.busy), 0);
        fin = 1;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (!fin) chk("run_timeout", 0, 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_done_pulse", int'(bus.done), 0);
    chk("post_busy", int'(bus.busy), 0);
    chk("post_out_valid", int'(bus.out_valid), 0);
    unpack_check();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.even = '0; bus.odd = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: all zero
    set_coef(0); build_exp();
    chk("model_t1_last", int'(exp_b[BYTES-1]), 8'h00);
    run(0, 0, -1, -1);

    // T2: even=0x1FFF, odd=0
    set_coef(1); build_exp();
    chk("model_t2_b0", int'(exp_b[0]), 8'hFF);
    chk("model_t2_b1", int'(exp_b[1]), 8'h1F);
    chk("model_t2_b2", int'(exp_b[2]), 8'h00);
    chk("model_t2_b3", int'(exp_b[3]), 8'hFC);
    chk("model_t2_b4", int'(exp_b[4]), 8'h7F);
    run(0, 0, -1, -1);

    // T3: only the last pair is all ones (coefficients 698, 699 -> bits 9074..9099)
    set_coef(2); build_exp();
    chk("model_t3_b1134", int'(exp_b[1134]), 8'hFC);
    chk("model_t3_b1135", int'(exp_b[1135]), 8'hFF);
    chk("model_t3_b1136", int'(exp_b[1136]), 8'hFF);
    chk("model_t3_b1137", int'(exp_b[1137]), 8'h0F);
    run(0, 0, -1, -1);

    // T4: random data with output backpressure
    set_coef(3); build_exp();
    run(0, 1, -1, -1);

    // T5: random input gaps and a stray start mid-run
    set_coef(3); build_exp();
    run(30, 0, 100, -1);

    // T6: reset after byte 500, then a fresh full run
    set_coef(3); build_exp();
    run(20, 1, -1, 500);
    set_coef(3); build_exp();
    run(20, 1, -1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
